alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Parametrised successor to the combinational ALU select decoder; decodes ALUOp/funct3/funct7 and executes the operation.
- Handles RV32I/RV64I integer ops in one cycle and M-extension MUL/DIV/REM iteratively, with a valid/ready handshake toward the EX stage.
- Sits in the EX stage. The pipeline stalls while ready_o is low.

Parameters:
- XLEN, 32, operand/result width (32 or 64).
- ENABLE_M, 1, 1 = M-extension ops executed; 0 = M encodings flagged illegal.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid_i  in  1  operation offered.
- ready_o  out  1  unit idle, can accept; combinational from state.
- alu_op_i  in  2  00 = ADD (ld/st/auipc), 01 = SUB (branch compare), 10 = R-type, 11 = I-type.
- funct3_i  in  3  instruction funct3.
- funct7_5_i  in  1  funct7[5].
- funct7_0_i  in  1  funct7[0] (M-extension marker; R-type only).
- a_i  in  XLEN  operand A.
- b_i  in  XLEN  operand B (rs2 or immediate).
- flush_i  in  1  abort in-flight op.
- result_o  out  XLEN  registered result.
- out_valid_o  out  1  one-cycle pulse, result_o valid.
- illegal_o  out  1  qualifies out_valid_o: undefined encoding.
- alu_sel_o  out  4  registered select code of last accepted op (trace only).

Behaviour:
- Reset (async, rst_n=0): state=IDLE, result_o=0, out_valid_o=0, illegal_o=0, alu_sel_o=0, all iteration registers 0. ready_o=1 as soon as state is IDLE.
- Accept: valid_i && ready_o && !flush_i at a rising edge.
- Select codes (package): ADD 0000, SUB 0001, OR 0100, AND 0101, XOR 0111, SLL 1000, SRL 1001, SRA 1010, SLT 1101, SLTU 1111. alu_op 00 and R/I ADD both use 0000.
- R-type decode on {funct7_5, funct3}:
  - 0000 ADD, 1000 SUB, 0001 SLL, 0010 SLT, 0011 SLTU, 0100 XOR, 0101 SRL, 1101 SRA, 0110 OR, 0111 AND.
  - Any other combination is illegal.
- I-type decode: funct7_5 is ignored except for funct3=101 (0 SRLI, 1 SRAI). funct3=001 with funct7_5=1 is illegal.
- Shift amount: b_i[log2(XLEN)-1:0]. SLT/SLTU return 0 or 1, zero-extended.
- Single-cycle ops: result registered at the accept edge. out_valid_o pulses in the next cycle (latency 1). ready_o stays high, so back-to-back accepts are allowed.
- Illegal op: result_o=0, illegal_o=1 with out_valid_o, latency 1.
- M ops (alu_op=10, funct7_0=1, ENABLE_M=1). funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- FSM: IDLE -> CALC -> FIX -> IDLE.
  - IDLE: on accept of an M op, latch operand magnitudes and sign flags, count=0.
  - CALC: one radix-2 step per cycle (shift-add multiply / restoring divide), XLEN cycles.
  - FIX: conditional negate, select low/high product or quotient/remainder, register result_o.
  - out_valid_o pulses the cycle after FIX, with state already IDLE.
  - Latency from accept edge to out_valid_o: XLEN+2 cycles. ready_o is low in CALC and FIX.
- Division fast paths (bypass CALC, latency 1):
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = a_i.
  - Signed overflow (a = MIN, b = -1): DIV = MIN, REM = 0.
- ENABLE_M=0: M encodings are illegal, latency 1. The CALC/FIX logic is not generated.
- Flush:
  - flush_i in any state forces IDLE at the next edge. No out_valid_o is produced for the aborted op.
  - flush_i with valid_i in the same cycle: the op is dropped.
  - A flush in the cycle a latency-1 result would appear does not suppress an already-registered out_valid_o.
- Reset mid-CALC: the result is discarded immediately and all outputs return to their reset values.
- Arithmetic wraps modulo 2^XLEN. The product is 2*XLEN internal and the quotient/remainder are XLEN.

Decomposition:
- Package alu_exec_pkg: ALUOp encodings, 4-bit select codes, M funct3 encodings, FSM state typedef.
- Sub-module alu_md_iter: the iterative multiply/divide datapath with count; start/done interface; contains CALC and FIX.
- Decode and single-cycle ALU stay in the top.

Test Plan:
- alu_op=10, f7_5=1, f3=000, a=5, b=7 -> out_valid next cycle, result=0xFFFFFFFE, alu_sel=0001.
- I-type f3=101, f7_5=1, a=0x80000000, b=4 -> result=0xF8000000. Then R-type f7_5=1, f3=010 -> illegal_o=1, result=0.
- MULH a=0xFFFFFFFF (-1), b=0x00000002 -> ready_o low 33 cycles, out_valid at cycle 34, result=0xFFFFFFFF. MULHU on the same operands -> result=0x00000001.
- DIV a=0x80000000, b=0xFFFFFFFF -> latency 1, result=0x80000000. REMU a=9, b=0 -> result=9.
- DIV a=-7, b=2 -> result=0xFFFFFFFD. Assert flush_i at CALC cycle 10 on a repeat -> no out_valid, ready_o high the next cycle, next ADD accepted.
- Back-to-back ADD/XOR/SLTU every cycle with valid_i high -> one out_valid per cycle, correct results. rst_n pulse mid-DIV -> outputs zero immediately.

Source files
------------

// File: rtl/alu_exec_pkg.sv
// Shared encodings for the ALU execute unit.
//   - ALUOp field values driven by the main decoder
//   - 4-bit ALU select codes (also exported on alu_sel_o for trace)
//   - M-extension funct3 encodings
//   - state type of the iterative multiply/divide engine
package alu_exec_pkg;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  localparam logic [3:0] SEL_ADD  = 4'b0000;
  localparam logic [3:0] SEL_SUB  = 4'b0001;
  localparam logic [3:0] SEL_OR   = 4'b0100;
  localparam logic [3:0] SEL_AND  = 4'b0101;
  localparam logic [3:0] SEL_XOR  = 4'b0111;
  localparam logic [3:0] SEL_SLL  = 4'b1000;
  localparam logic [3:0] SEL_SRL  = 4'b1001;
  localparam logic [3:0] SEL_SRA  = 4'b1010;
  localparam logic [3:0] SEL_SLT  = 4'b1101;
  localparam logic [3:0] SEL_SLTU = 4'b1111;

  localparam logic [2:0] M_MUL    = 3'b000;
  localparam logic [2:0] M_MULH   = 3'b001;
  localparam logic [2:0] M_MULHSU = 3'b010;
  localparam logic [2:0] M_MULHU  = 3'b011;
  localparam logic [2:0] M_DIV    = 3'b100;
  localparam logic [2:0] M_DIVU   = 3'b101;
  localparam logic [2:0] M_REM    = 3'b110;
  localparam logic [2:0] M_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } md_state_t;

endpackage

// File: rtl/alu_md_iter.sv
// Iterative radix-2 multiply/divide engine (IDLE -> CALC -> FIX -> IDLE).
// Operands are reduced to magnitudes at start; FIX applies the sign and picks
// the requested half, so the result is valid combinationally while done=1.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   flush          abort any operation, return to IDLE at next edge
//   start          launch an op (only asserted by the top while idle)
//   funct3         M-extension funct3 of the op being started
//   a, b           operands
//   idle           engine can accept (combinational from state)
//   done           FIX cycle: res holds the final value
//   res            final result
module alu_md_iter
  import alu_exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            idle,
  output logic            done,
  output logic [XLEN-1:0] res
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  md_state_t state, state_nxt;

  // acc holds {hi, lo}: product accumulator / multiplier for MUL,
  // {remainder, dividend->quotient} for DIV.
  logic [2*XLEN-1:0] acc, step_acc, mul_v;
  logic [XLEN-1:0]   opb, a_mag, b_mag, div_h;
  logic [CW-1:0]     count;
  logic              is_div, take_hi, neg;
  logic              a_sgn, b_sgn, sa, sb;
  logic [XLEN:0]     mul_sum, r_sh, r_sub;

  // Operand conditioning at start
  always_comb begin
    a_sgn = (funct3 == M_MULH) || (funct3 == M_MULHSU) ||
            (funct3 == M_DIV)  || (funct3 == M_REM);
    b_sgn = (funct3 == M_MULH) || (funct3 == M_DIV) || (funct3 == M_REM);
    sa    = a_sgn & a[XLEN-1];
    sb    = b_sgn & b[XLEN-1];
    a_mag = sa ? -a : a;
    b_mag = sb ? -b : b;
  end

  // One radix-2 step per CALC cycle
  always_comb begin
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);
    r_sh    = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    r_sub   = r_sh - {1'b0, opb};
    if (is_div) begin
      // Borrow out of r_sub means the trial subtraction is restored.
      step_acc = r_sub[XLEN] ? {r_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                             : {r_sub[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else begin
      step_acc = {mul_sum, acc[XLEN-1:1]};
    end
  end

  // FIX: sign restore and half selection
  always_comb begin
    mul_v = neg ? -acc : acc;
    div_h = take_hi ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
    if (is_div) res = neg ? -div_h : div_h;
    else        res = take_hi ? mul_v[2*XLEN-1:XLEN] : mul_v[XLEN-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_CALC;
      ST_CALC: if (count == LAST) state_nxt = ST_FIX;
      ST_FIX:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

  assign idle = (state == ST_IDLE);
  assign done = (state == ST_FIX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      opb     <= '0;
      count   <= '0;
      is_div  <= 1'b0;
      take_hi <= 1'b0;
      neg     <= 1'b0;
    end else if (start) begin
      acc     <= {{XLEN{1'b0}}, a_mag};
      opb     <= b_mag;
      count   <= '0;
      is_div  <= funct3[2];
      // MULH* and REM* read the upper half of acc.
      take_hi <= funct3[2] ? funct3[1] : (funct3[1:0] != 2'b00);
      // Remainder takes the dividend sign; quotient/product the xor.
      neg     <= (funct3 == M_REM) ? sa : (sa ^ sb);
    end else if (state == ST_CALC) begin
      acc   <= step_acc;
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// EX-stage ALU: decodes ALUOp/funct3/funct7 and executes RV32I/RV64I integer
// ops in one cycle; M-extension MUL/DIV/REM run on the iterative engine.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   valid_i / ready_o   request handshake (ready_o low while M op in flight)
//   alu_op_i            00 ADD, 01 SUB, 10 R-type, 11 I-type
//   funct3_i, funct7_5_i, funct7_0_i   instruction fields
//   a_i, b_i            operands (b_i is rs2 or immediate)
//   flush_i             abort in-flight op / drop offered op
//   result_o            registered result
//   out_valid_o         one-cycle pulse, result_o valid
//   illegal_o           with out_valid_o: encoding undefined, result_o = 0
//   alu_sel_o           select code of last accepted op (trace)
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int ENABLE_M = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [1:0]      alu_op_i,
  input  logic [2:0]      funct3_i,
  input  logic            funct7_5_i,
  input  logic            funct7_0_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  input  logic            flush_i,
  output logic [XLEN-1:0] result_o,
  output logic            out_valid_o,
  output logic            illegal_o,
  output logic [3:0]      alu_sel_o
);

  localparam int SHW = $clog2(XLEN);

  function automatic logic [XLEN-1:0] alu_fn(input logic [3:0] sel,
                                             input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] a_s, b_s;
    logic [SHW-1:0]         sh;
    a_s = a;
    b_s = b;
    sh  = b[SHW-1:0];
    case (sel)
      SEL_ADD:  alu_fn = a + b;
      SEL_SUB:  alu_fn = a - b;
      SEL_OR:   alu_fn = a | b;
      SEL_AND:  alu_fn = a & b;
      SEL_XOR:  alu_fn = a ^ b;
      SEL_SLL:  alu_fn = a << sh;
      SEL_SRL:  alu_fn = a >> sh;
      SEL_SRA:  alu_fn = a_s >>> sh;
      SEL_SLT:  alu_fn = {{(XLEN-1){1'b0}}, a_s < b_s};
      SEL_SLTU: alu_fn = {{(XLEN-1){1'b0}}, a < b};
      default:  alu_fn = '0;
    endcase
  endfunction

  logic [3:0]      sel_p0;
  logic            ill_p0, is_m_p0, fast_p0, b_zero, ovf;
  logic [XLEN-1:0] res_p0, fast_res;
  logic            accept, md_start, vld_p0;
  logic            md_idle, md_done;
  logic [XLEN-1:0] md_res;

  // Stage p0: decode
  always_comb begin
    sel_p0  = SEL_ADD;
    ill_p0  = 1'b0;
    is_m_p0 = 1'b0;
    case (alu_op_i)
      ALUOP_ADD: sel_p0 = SEL_ADD;
      ALUOP_SUB: sel_p0 = SEL_SUB;
      ALUOP_R: begin
        if (funct7_0_i) begin
          if (ENABLE_M != 0) is_m_p0 = 1'b1;
          else               ill_p0  = 1'b1;
        end else begin
          case ({funct7_5_i, funct3_i})
            4'b0000: sel_p0 = SEL_ADD;
            4'b1000: sel_p0 = SEL_SUB;
            4'b0001: sel_p0 = SEL_SLL;
            4'b0010: sel_p0 = SEL_SLT;
            4'b0011: sel_p0 = SEL_SLTU;
            4'b0100: sel_p0 = SEL_XOR;
            4'b0101: sel_p0 = SEL_SRL;
            4'b1101: sel_p0 = SEL_SRA;
            4'b0110: sel_p0 = SEL_OR;
            4'b0111: sel_p0 = SEL_AND;
            default: ill_p0 = 1'b1;
          endcase
        end
      end
      default: begin
        case (funct3_i)
          3'b000: sel_p0 = SEL_ADD;
          3'b001: if (funct7_5_i) ill_p0 = 1'b1; else sel_p0 = SEL_SLL;
          3'b010: sel_p0 = SEL_SLT;
          3'b011: sel_p0 = SEL_SLTU;
          3'b100: sel_p0 = SEL_XOR;
          3'b101: sel_p0 = funct7_5_i ? SEL_SRA : SEL_SRL;
          3'b110: sel_p0 = SEL_OR;
          default: sel_p0 = SEL_AND;
        endcase
      end
    endcase
  end

  // Division corner cases resolve in one cycle and never start the engine.
  always_comb begin
    b_zero  = (b_i == '0);
    ovf     = !funct3_i[0] && (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (&b_i);
    fast_p0 = is_m_p0 && funct3_i[2] && (b_zero || ovf);
    if (b_zero) fast_res = funct3_i[1] ? a_i : '1;
    else        fast_res = funct3_i[1] ? '0 : a_i;
    if (ill_p0)       res_p0 = '0;
    else if (fast_p0) res_p0 = fast_res;
    else              res_p0 = alu_fn(sel_p0, a_i, b_i);
  end

  assign ready_o  = md_idle;
  assign accept   = valid_i && ready_o && !flush_i;
  assign md_start = accept && is_m_p0 && !fast_p0;
  assign vld_p0   = accept && !md_start;

  generate
    if (ENABLE_M != 0) begin : g_md
      alu_md_iter #(.XLEN(XLEN)) u_md (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (flush_i),
        .start  (md_start),
        .funct3 (funct3_i),
        .a      (a_i),
        .b      (b_i),
        .idle   (md_idle),
        .done   (md_done),
        .res    (md_res)
      );
    end else begin : g_no_md
      assign md_idle = 1'b1;
      assign md_done = 1'b0;
      assign md_res  = '0;
    end
  endgenerate

  // Stage p1: registered result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_o    <= '0;
      out_valid_o <= 1'b0;
      illegal_o   <= 1'b0;
      alu_sel_o   <= '0;
    end else begin
      out_valid_o <= 1'b0;
      illegal_o   <= 1'b0;
      if (accept) begin
        alu_sel_o <= sel_p0;
        if (vld_p0) begin
          result_o    <= res_p0;
          out_valid_o <= 1'b1;
          illegal_o   <= ill_p0;
        end
      end else if (md_done && !flush_i) begin
        result_o    <= md_res;
        out_valid_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            valid_i, ready_o, flush_i;
  logic [1:0]      alu_op_i;
  logic [2:0]      funct3_i;
  logic            funct7_5_i, funct7_0_i;
  logic [XLEN-1:0] a_i, b_i, result_o;
  logic            out_valid_o, illegal_o;
  logic [3:0]      alu_sel_o;

  alu_exec_unit #(.XLEN(XLEN), .ENABLE_M(1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .alu_op_i    (alu_op_i),
    .funct3_i    (funct3_i),
    .funct7_5_i  (funct7_5_i),
    .funct7_0_i  (funct7_0_i),
    .a_i         (a_i),
    .b_i         (b_i),
    .flush_i     (flush_i),
    .result_o    (result_o),
    .out_valid_o (out_valid_o),
    .illegal_o   (illegal_o),
    .alu_sel_o   (alu_sel_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [XLEN-1:0] res;
    logic            ill;
    logic [3:0]      sel;
    string           tag;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  // Offer one op (waits for ready_o); optionally queue its expected response.
  task automatic send(input logic [1:0] op, input logic [2:0] f3, input logic f75,
                      input logic f70, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                      input logic want, input logic [XLEN-1:0] eres, input logic eill,
                      input logic [3:0] esel, input string tag);
    int n = 0;
    while (!ready_o && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready_o) begin
      checks++;
      errors++;
      $display("FAIL %s_ready_timeout: got ready 0 required 1", tag);
    end
    alu_op_i = op; funct3_i = f3; funct7_5_i = f75; funct7_0_i = f70;
    a_i = a; b_i = b; valid_i = 1'b1;
    if (want) q.push_back('{res: eres, ill: eill, sel: esel, tag: tag});
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_drain_timeout: got %0d pending required 0", tag, q.size());
    end
  endtask

  initial begin
    exp_t e;
    int   lowc, vcyc;

    rst_n = 1'b1; valid_i = 1'b0; flush_i = 1'b0;
    alu_op_i = '0; funct3_i = '0; funct7_5_i = 1'b0; funct7_0_i = 1'b0;
    a_i = '0; b_i = '0;

    fork
      forever begin
        @(negedge clk);
        if (rst_n && out_valid_o) begin
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out_valid: got result %0h required no output", result_o);
          end else begin
            e = q.pop_front();
            chk({e.tag, "_res"}, result_o, e.res);
            chk({e.tag, "_ill"}, illegal_o, e.ill);
            chk({e.tag, "_sel"}, alu_sel_o, e.sel);
          end
        end
      end
      begin
        #200000;
        $display("FAIL watchdog: got timeout required $finish");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_result", result_o, 0);
    chk("rst_out_valid", out_valid_o, 0);
    chk("rst_illegal", illegal_o, 0);
    chk("rst_alu_sel", alu_sel_o, 0);
    chk("rst_ready", ready_o, 1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Single-cycle ops, issued back to back
    send(2'b10, 3'b000, 1, 0, 32'd5, 32'd7, 1, 32'hFFFFFFFE, 0, 4'b0001, "r_sub");
    send(2'b00, 3'b000, 0, 0, 32'h10, 32'h20, 1, 32'h30, 0, 4'b0000, "op_add");
    send(2'b01, 3'b000, 0, 0, 32'd9, 32'd4, 1, 32'd5, 0, 4'b0001, "op_sub");
    send(2'b11, 3'b101, 1, 0, 32'h80000000, 32'd4, 1, 32'hF8000000, 0, 4'b1010, "srai");
    send(2'b11, 3'b101, 0, 0, 32'h80000000, 32'd4, 1, 32'h08000000, 0, 4'b1001, "srli");
    send(2'b10, 3'b010, 1, 0, 32'd3, 32'd4, 1, 32'h0, 1, 4'b0000, "r_illegal");
    send(2'b11, 3'b001, 1, 0, 32'd1, 32'd3, 1, 32'h0, 1, 4'b0000, "slli_illegal");
    send(2'b11, 3'b001, 0, 0, 32'd1, 32'd31, 1, 32'h80000000, 0, 4'b1000, "slli");
    send(2'b10, 3'b010, 0, 0, 32'hFFFFFFFF, 32'd1, 1, 32'd1, 0, 4'b1101, "slt");
    send(2'b10, 3'b011, 0, 0, 32'hFFFFFFFF, 32'd1, 1, 32'd0, 0, 4'b1111, "sltu");
    send(2'b11, 3'b110, 0, 0, 32'hF0, 32'h0F, 1, 32'hFF, 0, 4'b0100, "ori");
    send(2'b10, 3'b111, 0, 0, 32'hFF00, 32'h0FF0, 1, 32'h0F00, 0, 4'b0101, "and");
    send(2'b10, 3'b101, 1, 0, 32'h80000000, 32'h21, 1, 32'hC0000000, 0, 4'b1010, "sra_shmask");
    drain("single");

    // MULH: ready low XLEN+1 cycles, out_valid in cycle XLEN+2
    send(2'b10, 3'b001, 0, 1, 32'hFFFFFFFF, 32'd2, 1, 32'hFFFFFFFF, 0, 4'b0000, "mulh");
    lowc = 0; vcyc = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (!ready_o) lowc++;
      if (out_valid_o && vcyc == 0) vcyc = c;
    end
    chk("mulh_ready_low_cycles", lowc, 33);
    chk("mulh_latency", vcyc, 34);
    @(posedge clk); #1;

    send(2'b10, 3'b011, 0, 1, 32'hFFFFFFFF, 32'd2, 1, 32'h00000001, 0, 4'b0000, "mulhu");
    send(2'b10, 3'b000, 0, 1, 32'hFFFFFFFD, 32'd7, 1, 32'hFFFFFFEB, 0, 4'b0000, "mul");
    send(2'b10, 3'b010, 0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 0, 4'b0000, "mulhsu");
    drain("mul");

    // Division fast paths (latency 1)
    send(2'b10, 3'b100, 0, 1, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000, 0, 4'b0000, "div_ovf");
    @(negedge clk);
    chk("div_ovf_latency1", out_valid_o, 1);
    @(posedge clk); #1;
    send(2'b10, 3'b110, 0, 1, 32'h80000000, 32'hFFFFFFFF, 1, 32'h0, 0, 4'b0000, "rem_ovf");
    send(2'b10, 3'b111, 0, 1, 32'd9, 32'd0, 1, 32'd9, 0, 4'b0000, "remu_by0");
    send(2'b10, 3'b101, 0, 1, 32'd9, 32'd0, 1, 32'hFFFFFFFF, 0, 4'b0000, "divu_by0");

    // Iterative division
    send(2'b10, 3'b100, 0, 1, 32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFD, 0, 4'b0000, "div_neg");
    send(2'b10, 3'b110, 0, 1, 32'hFFFFFFF9, 32'd2, 1, 32'hFFFFFFFF, 0, 4'b0000, "rem_neg");
    send(2'b10, 3'b101, 0, 1, 32'd100, 32'd7, 1, 32'd14, 0, 4'b0000, "divu");
    send(2'b10, 3'b111, 0, 1, 32'd100, 32'd7, 1, 32'd2, 0, 4'b0000, "remu");
    drain("div");

    // Flush at CALC cycle 10: no result, idle next cycle, next ADD accepted
    send(2'b10, 3'b100, 0, 1, 32'hFFFFFFF9, 32'd2, 0, 32'h0, 0, 4'b0000, "div_flushed");
    repeat (9) @(posedge clk);
    #1;
    chk("calc_busy", ready_o, 0);
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    chk("flush_ready", ready_o, 1);
    send(2'b00, 3'b000, 0, 0, 32'd2, 32'd3, 1, 32'd5, 0, 4'b0000, "add_after_flush");
    drain("flush");

    // Back-to-back ADD/XOR/SLTU
    send(2'b00, 3'b000, 0, 0, 32'd1, 32'd2, 1, 32'd3, 0, 4'b0000, "b2b_add");
    send(2'b10, 3'b100, 0, 0, 32'hFF, 32'h0F, 1, 32'hF0, 0, 4'b0111, "b2b_xor");
    send(2'b10, 3'b011, 0, 0, 32'd3, 32'd5, 1, 32'd1, 0, 4'b1111, "b2b_sltu");

    // Flush together with valid: op dropped, trace select unchanged
    alu_op_i = 2'b01; a_i = 32'd8; b_i = 32'd1; valid_i = 1'b1; flush_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0; flush_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("flush_drop_sel", alu_sel_o, 4'b1111);

    // Flush in the cycle a registered latency-1 result is shown
    send(2'b11, 3'b100, 0, 0, 32'h0000AAAA, 32'h0000FFFF, 1, 32'h00005555, 0, 4'b0111, "xori_flushcycle");
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    drain("flushcycle");

    // Reset mid-DIV: outputs return to reset values immediately
    send(2'b10, 3'b101, 0, 1, 32'd100, 32'd3, 0, 32'h0, 0, 4'b0000, "divu_reset");
    repeat (5) @(posedge clk);
    #1;
    chk("mid_div_busy", ready_o, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_result", result_o, 0);
    chk("midrst_out_valid", out_valid_o, 0);
    chk("midrst_illegal", illegal_o, 0);
    chk("midrst_alu_sel", alu_sel_o, 0);
    chk("midrst_ready", ready_o, 1);
    @(negedge clk) rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    send(2'b00, 3'b000, 0, 0, 32'd7, 32'd8, 1, 32'd15, 0, 4'b0000, "add_after_reset");
    drain("final");

    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
